// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, FSM state encoding and id width for irq_controller
package irq_ctrl_pkg;
    localparam int IDW = 3;
    localparam logic [31:0] OFS_IMASK  = 32'h00;
    localparam logic [31:0] OFS_IPEND  = 32'h04;
    localparam logic [31:0] OFS_ICAUSE = 32'h08;
    localparam logic [31:0] OFS_IEOI   = 32'h0C;
    localparam logic [31:0] OFS_ICNT0  = 32'h1C;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest set index wins
// Ports: req (request vector) -> any (some bit set), idx (winning index, 0 when none)
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic             any,
    output logic [IDW-1:0]   idx
);
    always_comb begin
        any = |req;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req[i]) idx = IDW'(i);
    end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: latched, maskable, fixed-priority interrupt controller with ack/EOI handshake
// Ports: clk, reset (async, active-high); bus rd/wr/addr/wdata -> rdata (combinational);
//        irq_src level requests; irq/irq_id to the CPU; irq_ack pulse on exception entry.
// Build option: IRQ_STATS_EN adds per-source saturating 16-bit ack counters ICNT[i].
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 3,
    parameter logic [31:0] BASE_ADDR = 32'h40000024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_SRC-1:0] irq_src,
    output logic             irq,
    output logic [IDW-1:0]   irq_id,
    input  logic             irq_ack
);
    state_t           state, state_n;
    logic [N_SRC-1:0] src_q, pend, imask, req, sel_id, w1c, ack_clr;
    logic [IDW-1:0]   win, insvc, id_n, cid;
    logic             any, irq_n, ack, eoi, hold;
    logic [31:0]      cnt_rd;
    logic             unused_wdata;

    assign unused_wdata = ^wdata[31:N_SRC];
    assign req     = pend & imask;
    assign sel_id  = N_SRC'(1) << irq_id;
    assign hold    = |(req & sel_id);
    assign ack     = irq_ack && state == ST_ASSERT;
    assign eoi     = wr && addr == BASE_ADDR + OFS_IEOI && state == ST_SERVICE;
    assign w1c     = (wr && addr == BASE_ADDR + OFS_IPEND) ? wdata[N_SRC-1:0] : '0;
    assign ack_clr = ack ? sel_id : '0;
    assign cid     = state == ST_SERVICE ? insvc : irq_id;

    irq_prio_enc #(.N_SRC(N_SRC)) u_enc (.req(req), .any(any), .idx(win));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
        end else begin
            state  <= state_n;
            irq    <= irq_n;
            irq_id <= id_n;
        end
    end

    // irq_id only loads in IDLE, so a later higher-priority arrival never preempts.
    always_comb begin
        state_n = state;
        irq_n   = 1'b0;
        id_n    = irq_id;
        case (state)
            ST_IDLE: begin
                state_n = any ? ST_ASSERT : ST_IDLE;
                irq_n   = any;
                id_n    = any ? win : irq_id;
            end
            ST_ASSERT: begin
                state_n = irq_ack ? ST_SERVICE : hold ? ST_ASSERT : ST_IDLE;
                irq_n   = !irq_ack && hold;
            end
            ST_SERVICE: state_n = eoi ? ST_IDLE : ST_SERVICE;
            default:    state_n = ST_IDLE;
        endcase
    end

    // New rising edges are ORed in last so a set beats W1C and ack clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q <= '0;
            pend  <= '0;
            imask <= '0;
            insvc <= '0;
        end else begin
            src_q <= irq_src;
            pend  <= (pend & ~w1c & ~ack_clr) | (irq_src & ~src_q);
            if (wr && addr == BASE_ADDR + OFS_IMASK) imask <= wdata[N_SRC-1:0];
            if (ack) insvc <= irq_id;
        end
    end

`ifdef IRQ_STATS_EN
    logic [N_SRC-1:0][15:0] icnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) icnt <= '0;
        else
            for (int i = 0; i < N_SRC; i++)
                if (wr && addr == BASE_ADDR + OFS_ICNT0 + 32'(4 * i)) icnt[i] <= '0;
                else if (ack && irq_id == IDW'(i) && !(&icnt[i])) icnt[i] <= icnt[i] + 16'd1;
    end

    always_comb begin
        cnt_rd = '0;
        for (int i = 0; i < N_SRC; i++)
            if (addr == BASE_ADDR + OFS_ICNT0 + 32'(4 * i)) cnt_rd = {16'd0, icnt[i]};
    end
`else
    assign cnt_rd = '0;
`endif

    assign rdata = !rd                           ? '0 :
                   addr == BASE_ADDR + OFS_IMASK  ? 32'(imask) :
                   addr == BASE_ADDR + OFS_IPEND  ? 32'(pend) :
                   addr == BASE_ADDR + OFS_ICAUSE ? 32'({state == ST_SERVICE, 1'b0, cid}) :
                   cnt_rd;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed and randomized checks of irq_controller against a behavioural model
module tb_irq_controller;
    localparam int          N = 3;
    localparam logic [31:0] B = 32'h40000024;

    logic          clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, irq_ack = 1'b0;
    logic [31:0]   addr = '0, wdata = '0, rdata;
    logic [N-1:0]  irq_src = '0;
    logic          irq;
    logic [2:0]    irq_id;
    int            n_cmp = 0, n_bad = 0;

    logic [N-1:0]  m_pend, m_mask, m_srcq;
    int            m_st, m_id, m_svc, m_cnt[N];
    logic          m_irq;

    always #5 clk = ~clk;

    irq_controller #(.N_SRC(N), .BASE_ADDR(B)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq_src(irq_src), .irq(irq), .irq_id(irq_id), .irq_ack(irq_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_pend = '0; m_mask = '0; m_srcq = '0;
        m_st = 0; m_id = 0; m_svc = 0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Model states: 0 idle, 1 request presented, 2 in service.
    task automatic m_step();
        logic [N-1:0] req;
        int win, st, nid;
        logic nirq, ackd;
        req = m_pend & m_mask;
        win = -1;
        for (int i = 0; i < N; i++) if (req[i] && win < 0) win = i;
        ackd = irq_ack && m_st == 1;
        st = m_st; nid = m_id; nirq = 1'b0;
        if (m_st == 0 && win >= 0) begin st = 1; nirq = 1'b1; nid = win; end
        else if (m_st == 1) begin
            if (irq_ack) st = 2;
            else if (!req[m_id]) st = 0;
            else nirq = 1'b1;
        end else if (m_st == 2 && wr && addr == B + 32'hC) st = 0;
        if (ackd) begin
            m_svc = m_id;
            if (m_cnt[m_id] < 65535) m_cnt[m_id]++;
        end
        for (int i = 0; i < N; i++) if (wr && addr == B + 32'h1C + 32'(4 * i)) m_cnt[i] = 0;
        if (wr && addr == B + 32'h4) m_pend = m_pend & ~wdata[N-1:0];
        if (ackd) m_pend[m_id] = 1'b0;
        m_pend = m_pend | (irq_src & ~m_srcq);
        if (wr && addr == B) m_mask = wdata[N-1:0];
        m_srcq = irq_src; m_st = st; m_irq = nirq; m_id = nid;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [2:0] cid;
        cid = 3'(m_st == 2 ? m_svc : m_id);
        if (a == B) return 32'(m_mask);
        if (a == B + 32'h4) return 32'(m_pend);
        if (a == B + 32'h8) return {27'd0, m_st == 2, 1'b0, cid};
`ifdef IRQ_STATS_EN
        for (int i = 0; i < N; i++) if (a == B + 32'h1C + 32'(4 * i)) return 32'(m_cnt[i]);
`endif
        return 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) m_reset(); else m_step();
        @(negedge clk);
        check("irq", 32'(irq), 32'(m_irq));
        if (m_irq) check("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1;
        #1 check(tag, rdata, exp);
        rd = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] s);
        irq_src = s;
        tick();
        irq_src = '0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] ofs [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h24, 32'h28};
        m_reset();
        tick(); tick();
        reset = 1'b0;
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        rd_exp("rst_imask", B, 32'd0);
        rd_exp("rst_ipend", B + 32'h4, 32'd0);
        rd_exp("rst_icause", B + 32'h8, 32'd0);

        bus_wr(B, 32'h7);
        pulse(3'b010);
        tick();
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_id", 32'(irq_id), 32'd1);
        do_ack();
        check("t1_irq_ack", 32'(irq), 32'd0);
        rd_exp("t1_icause", B + 32'h8, 32'h11);
        rd_exp("t1_ipend", B + 32'h4, 32'd0);
        bus_wr(B + 32'hC, 32'd0);

        pulse(3'b101);
        tick();
        check("t2_id", 32'(irq_id), 32'd0);
        do_ack();
        bus_wr(B + 32'hC, 32'd0);
        check("t2_gap", 32'(irq), 32'd0);
        tick();
        check("t2_irq", 32'(irq), 32'd1);
        check("t2_id2", 32'(irq_id), 32'd2);
        do_ack();
        bus_wr(B + 32'hC, 32'd0);

        bus_wr(B, 32'h0);
        pulse(3'b010);
        tick(); tick();
        rd_exp("t3_ipend", B + 32'h4, 32'h2);
        check("t3_masked", 32'(irq), 32'd0);
        bus_wr(B, 32'h2);
        tick();
        check("t3_irq", 32'(irq), 32'd1);
        check("t3_id", 32'(irq_id), 32'd1);
        do_ack();
        bus_wr(B + 32'hC, 32'd0);

        bus_wr(B, 32'h7);
        pulse(3'b100);
        tick();
        check("t4_irq", 32'(irq), 32'd1);
        bus_wr(B + 32'h4, 32'h4);
        tick();
        check("t4_drop", 32'(irq), 32'd0);
        rd_exp("t4_icause", B + 32'h8, 32'h2);
        irq_src = 3'b100;
        bus_wr(B + 32'h4, 32'h4);
        irq_src = '0;
        rd_exp("t4_setwins", B + 32'h4, 32'h4);
        tick();
        do_ack();
        bus_wr(B + 32'hC, 32'd0);

        pulse(3'b001);
        tick();
        do_ack();
        do_ack();
        check("t5_ign_ack", 32'(irq), 32'd0);
        rd_exp("t5_icause", B + 32'h8, 32'h10);
        bus_wr(B + 32'h10, 32'h0);
        rd_exp("t5_unmapped", B + 32'h10, 32'd0);
        rd_exp("t5_outside", 32'h40000000, 32'd0);
        reset = 1'b1;
        #1 check("t5_async_irq", 32'(irq), 32'd0);
        irq_src = 3'b111;
        tick();
        reset = 1'b0;
        rd_exp("t5_imask", B, 32'd0);
        rd_exp("t5_icause0", B + 32'h8, 32'd0);
        tick(); tick(); tick();
        check("t5_noirq", 32'(irq), 32'd0);
        irq_src = '0;

        bus_wr(B, 32'h7);
        bus_wr(B + 32'h4, 32'h7);
        bus_wr(B + 32'h1C, 32'd0);
        for (int k = 0; k < 3; k++) begin
            pulse(3'b001);
            tick();
            do_ack();
            bus_wr(B + 32'hC, 32'd0);
        end
`ifdef IRQ_STATS_EN
        rd_exp("t6_icnt0", B + 32'h1C, 32'd3);
        bus_wr(B + 32'h1C, 32'd0);
        rd_exp("t6_icnt0_clr", B + 32'h1C, 32'd0);
`else
        rd_exp("t6_icnt0_absent", B + 32'h1C, 32'd0);
`endif

        for (int c = 0; c < 3000; c++) begin
            irq_src = N'($urandom);
            irq_ack = irq ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
            wr = $urandom_range(5) == 0;
            addr = B + ofs[$urandom_range(8)];
            wdata = (addr == B && $urandom_range(3) != 0) ? 32'h7 : $urandom;
            rd = $urandom_range(1) == 1;
            #1 check("rnd_rdata", rdata, rd ? m_read(addr) : 32'd0);
            tick();
            wr = 1'b0; rd = 1'b0; irq_ack = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
